// File: rtl/awgn_urng_sched.sv
// awgn_urng_sched: sequencing controller and round-robin word scheduler for
// a single Tausworthe URNG core shared by NUM_REQ noise lanes.
// The core is held in reset for RST_CYCLES cycles. Its first WARMUP words
// are then discarded. After that, each cycle's core word goes to at most one
// requester in round-robin order.
module awgn_urng_sched #(
    parameter int NUM_REQ    = 4,
    parameter int RST_CYCLES = 2,
    parameter int WARMUP     = 8,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       reseed_req,
    output logic                       urng_rstn,
    input  logic [31:0]                urng_data,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [31:0]                out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       ready,
    output logic [CNT_W-1:0]           words_served
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int WC_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [WC_W-1:0]      warm_cnt_q, warm_cnt_d;
    logic                 urng_rstn_q, urng_rstn_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     words_q, words_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 sel_valid;
    logic [ID_W-1:0]      sel;
    logic [ID_W-1:0]      cand_idx;
    int                   cand;

    // Round-robin pick: first requester at or after ptr+1, wrapping; walking offsets downward leaves the nearest hit
    always_comb begin
        sel_valid = 1'b0;
        sel       = ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (req[cand_idx]) begin
                sel_valid = 1'b1;
                sel       = cand_idx;
            end
        end
    end

    // Next-state logic: reseed overrides everything, otherwise SEED -> WARM -> RUN with grants only in RUN
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        warm_cnt_d  = warm_cnt_q;
        urng_rstn_d = urng_rstn_q;
        gnt_d       = '0;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ready_d     = ready_q;
        words_d     = words_q;
        ptr_d       = ptr_q;
        if (reseed_req) begin
            state_d     = SEED;
            rst_cnt_d   = '0;
            urng_rstn_d = 1'b0;
            ready_d     = 1'b0;
        end else begin
            case (state_q)
                SEED: begin
                    urng_rstn_d = 1'b0;
                    if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                        state_d     = WARM;
                        warm_cnt_d  = '0;
                        urng_rstn_d = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                WARM: begin
                    if (warm_cnt_q == WC_W'(WARMUP - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WC_W'(1);
                    end
                end
                RUN: begin
                    if (sel_valid) begin
                        gnt_d      = NUM_REQ'(1) << sel;
                        out_id_d   = sel;
                        out_data_d = urng_data;
                        ptr_d      = sel;
                        words_d    = words_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = SEED;
                    rst_cnt_d   = '0;
                    urng_rstn_d = 1'b0;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; rstn wins over reseed and puts requester 0 first in line
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= SEED;
            rst_cnt_q   <= '0;
            warm_cnt_q  <= '0;
            urng_rstn_q <= 1'b0;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ready_q     <= 1'b0;
            words_q     <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            warm_cnt_q  <= warm_cnt_d;
            urng_rstn_q <= urng_rstn_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ready_q     <= ready_d;
            words_q     <= words_d;
            ptr_q       <= ptr_d;
        end
    end

    assign urng_rstn    = urng_rstn_q;
    assign gnt          = gnt_q;
    assign out_data     = out_data_q;
    assign out_id       = out_id_q;
    assign ready        = ready_q;
    assign words_served = words_q;

endmodule

// File: doc/awgn_urng_sched.md
Name: awgn_urng_sched

Overview:
- Controller and round-robin scheduler for a single Tausworthe URNG core (32-bit output, one new word per clock, seeds fixed by parameters, synchronous active-low reset).
- Sequences the core: reset pulse, warm-up discard, then run.
- Shares the core's output stream between NUM_REQ consumers, such as Box-Muller or CLT noise lanes.
- Guarantees that no URNG word is delivered to more than one consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- RST_CYCLES, 2, number of cycles urng_rstn is held low per (re)seed sequence (>=1).
- WARMUP, 8, number of URNG words discarded after release before any grant (>=1).
- CNT_W, 32, width of the words_served counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous reset, active low.
- reseed_req  in  1  single-cycle pulse: restart the generator sequence.
- urng_rstn  out  1  reset to the URNG core (active low).
- urng_data  in  32  URNG core data_out.
- req  in  NUM_REQ  per-requester level request; held until granted.
- gnt  out  NUM_REQ  one-hot grant pulse; the word on out_data belongs to this requester.
- out_data  out  32  granted URNG word.
- out_id  out  clog2(NUM_REQ)  index of the granted requester.
- ready  out  1  high in the RUN state only.
- words_served  out  CNT_W  total grants since the last rstn.

Behaviour:
- Reset (rstn=0), effective at the next edge:
  - state=SEED, rst_cnt=0, urng_rstn=0, gnt=0, out_data=0, out_id=0, ready=0, words_served=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: SEED, WARM, RUN.
- SEED:
  - urng_rstn=0; rst_cnt increments each cycle.
  - When rst_cnt==RST_CYCLES-1, go to WARM and clear warm_cnt. urng_rstn is registered and goes high on the same edge.
- WARM:
  - urng_rstn=1; warm_cnt increments each cycle.
  - Go to RUN when warm_cnt==WARMUP-1.
  - No grants in WARM; requests stay pending.
- RUN:
  - ready=1.
  - Each cycle with req!=0, select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - On the next edge: gnt=onehot(sel), out_id=sel, out_data=urng_data as sampled that cycle, ptr=sel, words_served+=1.
  - Latency: request seen in cycle t -> gnt/out_data valid in cycle t+1, for one cycle only.
- Consumer protocol:
  - A requester that wants another word keeps req high after gnt.
  - The scheduler may grant it again only per RR order.
  - A continuously requesting set of k requesters is each served once every k cycles.
- Throughput: at most one grant per cycle. The URNG advances every cycle, so successive grants always carry distinct consecutive core words.
- If req==0 in RUN: gnt=0 and out_data holds its last value. The pointer is unchanged, and the URNG words of that cycle are discarded.
- reseed_req:
  - Accepted in any state. On the next edge: state=SEED, rst_cnt=0, ready=0, gnt=0.
  - A grant that would have been issued in that cycle is suppressed, because reseed wins over req.
  - words_served and ptr are preserved.
  - reseed_req during SEED restarts the RST_CYCLES count.
- words_served wraps modulo 2^CNT_W.
- rstn has priority over reseed_req.
- gnt is always one-hot or zero.
- gnt is never asserted while ready was low in the previous cycle.

Test Plan:
- Reset release, NUM_REQ=4, RST_CYCLES=2, WARMUP=8, req=4'b1111 held:
  - urng_rstn low for 2 cycles after rstn rises, then high.
  - ready rises 8 cycles later; first gnt appears the cycle after ready.
  - gnt order is 0001,0010,0100,1000,0001.
  - out_data equals the core words 9,10,11,... after release. Check against a reference Tausworthe model.
- Sparse requests, req=4'b1010 in RUN:
  - Grants alternate 0010,1000,0010.
  - After 6 grants, words_served=6 and out_id sequence is 1,3,1,3,1,3.
- Pointer wrap: ptr=3 (last grant to req3), then req=4'b1001 -> next grant to requester 0, then 3.
- Idle gap: req=0 for 5 cycles after a grant to requester 2, then req=4'b0111.
  - gnt=0 and out_data held during the gap.
  - Next grant goes to requester 0 (search from 3 wraps to 0).
  - out_data equals the core word of the request cycle, not a stale one.
- Reseed mid-run: reseed_req pulse in the same cycle as req=4'b0001.
  - No gnt follows; ready=0 and urng_rstn=0 for 2 cycles.
  - After the 8-cycle warm-up, out_data repeats the same word sequence as after the initial reset.
  - words_served continues from its prior value.
- rstn asserted during WARM together with reseed_req: all outputs take reset values and words_served=0. Then the normal SEED/WARM/RUN sequence follows.
